// File: rtl/solicitante.sv
// Requester side of a request/grant/hold/discharge handshake with timeouts
// on grant and on discharge, and a wrapping count of completed transactions.
module solicitante #(
  parameter int unsigned TO_REQ  = 15,
  parameter int unsigned TO_DESC = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] len,
  input  logic       a_e,
  input  logic       c,
  output logic       R,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [7:0] n_ok
);

  localparam int unsigned LEN_W = 8;
  localparam int unsigned TO_W  = 16;

  // Three-bit encoding leaves spare codes; any of them falls back to IDLE.
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] REQ    = 3'd1;
  localparam logic [2:0] HOLD   = 3'd2;
  localparam logic [2:0] WAIT_C = 3'd3;

  logic [2:0]       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] hold_q, hold_d;
  logic [TO_W-1:0]  to_q, to_d;
  logic [LEN_W-1:0] n_ok_d;
  logic             done_d, err_d;

  // State register and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      len_q   <= '0;
      hold_q  <= '0;
      to_q    <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      n_ok    <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hold_q  <= hold_d;
      to_q    <= to_d;
      done    <= done_d;
      err     <= err_d;
      n_ok    <= n_ok_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hold_d  = hold_q;
    to_d    = to_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    n_ok_d  = n_ok;
    case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = (len == '0) ? LEN_W'(1) : len;
          to_d    = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (a_e) begin
          hold_d  = len_q;
          to_d    = '0;
          state_d = HOLD;
        end else if (to_q == TO_W'(TO_REQ - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      HOLD: begin
        hold_d = hold_q - LEN_W'(1);
        // Losing a_e while holding is a protocol violation, even on the last cycle.
        if (!a_e) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else if (hold_q == LEN_W'(1)) begin
          to_d    = '0;
          state_d = WAIT_C;
        end
      end
      WAIT_C: begin
        if (c) begin
          done_d  = 1'b1;
          n_ok_d  = n_ok + LEN_W'(1);
          state_d = IDLE;
        end else if (to_q == TO_W'(TO_DESC - 1)) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          to_d = to_q + TO_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Pure decodes of the state register; spare codes read as inactive.
  assign R    = (state_q == REQ) || (state_q == HOLD);
  assign busy = (state_q == REQ) || (state_q == HOLD) || (state_q == WAIT_C);

endmodule

// File: tb/tb_solicitante.sv
// Scoreboard bench for solicitante: scripted responder behaviour per transaction,
// outcome predicted from timing rules, checked by an independent monitor.
module tb_solicitante;

  localparam int TO_REQ  = 15;
  localparam int TO_DESC = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] len;
  logic       a_e;
  logic       c;
  logic       R;
  logic       busy;
  logic       done;
  logic       err;
  logic [7:0] n_ok;

  solicitante #(.TO_REQ(TO_REQ), .TO_DESC(TO_DESC)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .len   (len),
    .a_e   (a_e),
    .c     (c),
    .R     (R),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .n_ok  (n_ok)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_done;
    int cyc;
    int n_ok;
    int r_cnt;
    int busy_cnt;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_n_ok = 0;
  int   r_tally = 0;
  int   b_tally = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // One transaction, started at the current negedge with the DUT idle.
  // g: cycle a_e rises; h: hold cycle where a_e drops (0 = never);
  // d: WAIT_C cycle where c rises; noise: random start/c while they must be ignored.
  task automatic run_txn(input int len_in, input int g, input int h, input int d,
                         input bit noise);
    int   lenp, end_k, r_exp;
    bit   is_done;
    exp_t e;
    lenp = (len_in == 0) ? 1 : len_in;
    if (g > TO_REQ) begin
      end_k = TO_REQ + 1; is_done = 1'b0; r_exp = TO_REQ;
    end else if (h > 0 && h <= lenp) begin
      end_k = g + h + 1; is_done = 1'b0; r_exp = g + h;
    end else begin
      r_exp = g + lenp;
      if (d <= TO_DESC) begin
        end_k = g + lenp + d + 1; is_done = 1'b1;
      end else begin
        end_k = g + lenp + TO_DESC + 1; is_done = 1'b0;
      end
    end
    if (is_done) exp_n_ok = (exp_n_ok + 1) % 256;
    e = '{is_done, cyc + end_k, exp_n_ok, r_exp, end_k - 1};
    q.push_back(e);
    start = 1'b1; len = 8'(len_in); a_e = 1'b0; c = 1'b0;
    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      if (k == end_k) begin
        start = 1'b0; a_e = 1'b0; c = 1'b0;
      end else begin
        start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
        a_e   = (k >= g) && !(h > 0 && k == g + h);
        if (k >= g + lenp + 1) c = (k >= g + lenp + d);
        else c = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
    end
  endtask

  // Monitor: pops the scoreboard on every done/err pulse.
  always @(negedge clk) begin
    if (reset) begin
      r_tally = 0; b_tally = 0;
    end else begin
      r_tally += int'(R);
      b_tally += int'(busy);
      if (done || err) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_event: done=%0b err=%0b at cycle %0d, none expected",
                   done, err, cyc);
        end else begin
          mon_e = q.pop_front();
          chk("done_err_excl", int'(done && err), 0);
          chk("event_is_done", int'(done), int'(mon_e.is_done));
          chk("event_cycle", cyc, mon_e.cyc);
          chk("n_ok", int'(n_ok), mon_e.n_ok);
          chk("r_cycles", r_tally, mon_e.r_cnt);
          chk("busy_cycles", b_tally, mon_e.busy_cnt);
        end
        r_tally = 0; b_tally = 0;
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        mon_e = q.pop_front();
        checks++; errors++;
        $display("FAIL missing_event: nothing by cycle %0d, expected %s at cycle %0d",
                 cyc, mon_e.is_done ? "done" : "err", mon_e.cyc);
        r_tally = 0; b_tally = 0;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int lenr, gr, hr, dr, sel;
    reset = 1'b1; start = 1'b0; len = 8'd0; a_e = 1'b0; c = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_R", int'(R), 0);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    chk("reset_err", int'(err), 0);
    chk("reset_n_ok", int'(n_ok), 0);
    reset = 1'b0;
    @(negedge clk);

    run_txn(3, 2, 0, 1, 1'b0);     // compliant, registered responder
    run_txn(3, 1, 0, 2, 1'b0);
    run_txn(0, 2, 0, 1, 1'b0);     // zero length holds one cycle
    run_txn(5, 99, 0, 1, 1'b0);    // never granted
    run_txn(4, 2, 0, 99, 1'b0);    // never discharged
    run_txn(6, 2, 3, 1, 1'b0);     // a_e dropped mid-hold
    run_txn(2, 15, 0, 1, 1'b1);    // grant on last REQ cycle
    run_txn(2, 16, 0, 1, 1'b1);    // grant one cycle too late
    run_txn(2, 1, 0, 4, 1'b1);     // discharge on last WAIT_C cycle
    run_txn(2, 1, 0, 5, 1'b1);     // discharge one cycle too late
    run_txn(4, 1, 4, 1, 1'b1);     // a_e dropped on final hold cycle

    // Reset in the middle of HOLD.
    start = 1'b1; len = 8'd10; a_e = 1'b1; c = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    chk("hold_R_before_reset", int'(R), 1);
    reset = 1'b1;
    @(negedge clk);
    chk("mid_hold_reset_R", int'(R), 0);
    chk("mid_hold_reset_busy", int'(busy), 0);
    chk("mid_hold_reset_n_ok", int'(n_ok), 0);
    chk("mid_hold_reset_err", int'(err), 0);
    @(negedge clk);
    reset = 1'b0; a_e = 1'b0;
    exp_n_ok = 0;
    @(negedge clk);

    // 256 completions bring n_ok back to zero.
    for (int i = 0; i < 256; i++) begin
      run_txn($urandom_range(0, 3), $urandom_range(1, 2), 0, $urandom_range(1, 2), 1'b1);
    end
    chk("n_ok_wrap", int'(n_ok), 0);

    for (int i = 0; i < 80; i++) begin
      sel  = $urandom_range(0, 9);
      lenr = ($urandom_range(0, 9) == 0) ? 255 : $urandom_range(0, 6);
      gr   = (sel == 0) ? $urandom_range(14, 17) : $urandom_range(1, 3);
      hr   = (sel == 1) ? $urandom_range(1, (lenr == 0) ? 1 : lenr) : 0;
      dr   = (sel == 2) ? $urandom_range(3, 6) : $urandom_range(1, 2);
      run_txn(lenr, gr, hr, dr, 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/solicitante.md
SOLICITANTE -- requirements
Module: solicitante

Interface
REQ-001 Parameter TO_REQ, default 15, SHALL set the maximum number of cycles spent in REQ awaiting a grant.
REQ-002 Parameter TO_DESC, default 4, SHALL set the maximum number of cycles spent in WAIT_C awaiting discharge.
REQ-003 clk  input  1  clock; all state SHALL change on the rising edge.
REQ-004 reset  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request one transaction; sampled only in IDLE.
REQ-006 len  input  8  number of cycles R is held after grant; latched on an accepted start.
REQ-007 a_e  input  1  active/wait indication from responder.
REQ-008 c  input  1  discharge indication from responder.
REQ-009 R  output  1  request line to responder; decoded from the state register only, with no combinational path from any input.
REQ-010 busy  output  1  high when state != IDLE.
REQ-011 done  output  1  one-cycle registered pulse on successful completion.
REQ-012 err  output  1  one-cycle registered pulse on timeout or protocol error.
REQ-013 n_ok  output  8  count of successful transactions; wraps 255 -> 0.

Function
REQ-014 The block SHALL have four states, IDLE, REQ, HOLD and WAIT_C; R SHALL be 1 exactly in REQ and HOLD.
REQ-015 IDLE: start=1 SHALL latch len (len=0 stored as 1), clear the timeout counter, and move to REQ; start=0 SHALL stay in IDLE.
REQ-016 start SHALL be ignored in every state other than IDLE, with no queuing.
REQ-017 REQ: an edge with a_e=1 SHALL move to HOLD and load the hold counter with the latched len (the grant edge).
REQ-018 REQ: an edge with a_e=0 SHALL increment the timeout counter; at TO_REQ cycles in REQ without grant the block SHALL pulse err and move to IDLE.
REQ-019 HOLD: R SHALL stay 1 for exactly len cycles after the grant edge; the counter SHALL decrement each edge, and on the edge where it equals 1 the block SHALL move to WAIT_C.
REQ-020 HOLD: a_e=0 at any edge SHALL be a protocol error: pulse err, move to IDLE, R=0 on the next cycle.
REQ-021 WAIT_C: R=0; an edge with c=1 SHALL pulse done, increment n_ok, and move to IDLE.
REQ-022 WAIT_C: at TO_DESC cycles without c=1 the block SHALL pulse err, move to IDLE, and leave n_ok unchanged.
REQ-023 c=1 outside WAIT_C SHALL be ignored.
REQ-024 done and err SHALL never both be 1 in the same cycle.
REQ-025 Latency from accepted start to R=1 SHALL be 1 cycle.
REQ-026 With a compliant responder, done SHALL pulse len+3 or len+4 cycles after the accepted start.
REQ-027 Unused state encodings SHALL recover to IDLE on the next edge with outputs inactive.

Reset
REQ-028 reset=1 at an edge SHALL force IDLE and set R=0, busy=0, done=0, err=0, n_ok=0, and clear the latched len and all counters.
REQ-029 reset SHALL take priority over every transition, including mid-HOLD and mid-WAIT_C.

Verification
REQ-030 Reset check: hold reset 2 cycles -> R=0, busy=0, done=0, err=0, n_ok=0.
REQ-031 Normal transaction: start with len=3 against a compliant responder model -> R high 1-2 cycles pre-grant plus exactly 3 cycles post-grant, c observed, done pulses once, n_ok=1, busy=0 afterwards.
REQ-032 Zero length: start with len=0 -> R held exactly 1 cycle post-grant, done pulses once.
REQ-033 No grant: a_e forced 0, start with len=5 -> err pulses after 15 cycles in REQ, R=0 next cycle, n_ok unchanged.
REQ-034 No discharge: c forced 0 after a valid grant -> err pulses after 4 cycles in WAIT_C, done never pulses.
REQ-035 Reset and ignored start: reset during HOLD -> R=0 next cycle and n_ok=0; start pulsed while busy -> no second transaction; 256 completed transactions -> n_ok=0.
